riscv_dmem_ctrl: RTL and testbench
==================================

Name: riscv_dmem_ctrl

Overview:
- Data-memory controller directly downstream of the pipelined RV32I core's EX-stage data port.
- Consumes the core's registered rd/we/addr/wdata/wmask request and drives a single-outstanding req/ack system bus.
- Returns the raw 32-bit word read from the bus; the core's MEM stage performs byte rotation and sign extension.
- Generates the core's stall input while a bus transaction is outstanding; detects misaligned accesses, bus errors and bus timeouts.

Parameters:
- TIMEOUT, 255, cycles in BUS state without I_bus_ack before the access is aborted (range 1..2^TIMEOUT_W-1).
- TIMEOUT_W, 8, width of the timeout counter.

Ports:
- I_clk  in  1  clock
- I_rst  in  1  reset, asynchronous, active-high
- I_rd  in  1  core load request
- I_we  in  1  core store request
- I_addr  in  32  byte address
- I_wdata  in  32  store data, unshifted (byte/half in low bits)
- I_wmask  in  4  core byte mask, unshifted: 0001 SB, 0011 SH, 1111 SW
- O_rdata  out  32  raw bus word of last completed load
- O_stall  out  1  to core stall input
- O_done  out  1  one-cycle pulse on access completion
- O_err  out  1  one-cycle pulse, coincident with O_done, on a failed access
- O_err_cause  out  2  01 bus error, 10 timeout, 11 misaligned; held until next O_err
- O_bus_req  out  1  bus request, held until ack
- O_bus_we  out  1  bus write
- O_bus_addr  out  32  word address, {I_addr[31:2],2'b00}
- O_bus_wdata  out  32  lane-aligned write data
- O_bus_be  out  4  lane-aligned byte enables
- I_bus_ack  in  1  bus completion strobe
- I_bus_rdata  in  32  bus read data, valid with ack
- I_bus_err  in  1  bus error, sampled only with ack

Behaviour:
- Reset, async: state IDLE, every output 0 (O_rdata 0, O_err_cause 00), timeout counter 0. Takes effect mid-transaction: O_bus_req drops immediately and the access is abandoned.
- States:
  - IDLE: no access.
  - BUS: O_bus_req=1, waiting for ack.
  - DONE: one cycle; O_done=1; O_rdata updated.
- Request acceptance:
  - Requests are accepted in IDLE or DONE when I_rd|I_we=1.
  - I_we has priority if both are asserted; the access is then a write.
  - Requests seen in BUS are ignored.
- Lane alignment:
  - O_bus_be = (I_wmask << I_addr[1:0]) truncated to 4 bits.
  - O_bus_wdata = I_wdata << (8*I_addr[1:0]).
  - Reads use be=1111.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0, where size comes from the wmask (writes) or from addr alone, treated as a word, for reads.
  - No bus access is made; go directly to DONE with O_err=1, cause 11.
  - O_rdata is loaded with 0 for reads.
- Capture: on acceptance, the bus address/we/wdata/be registers load and the FSM enters BUS next cycle, so O_bus_req rises 1 cycle after the request.
- O_stall (combinational):
  - 1 when state==BUS.
  - 1 in the acceptance cycle (request valid in IDLE or DONE and not misaligned).
  - 0 in DONE unless a new request is accepted in that DONE cycle.
- BUS, I_bus_ack=1:
  - Go to DONE.
  - Reads: O_rdata <= I_bus_err ? 0 : I_bus_rdata.
  - If I_bus_err=1: O_err pulse, cause 01.
  - Counter clears.
- BUS, no ack:
  - The counter increments.
  - When the counter reaches TIMEOUT-1 without ack: O_bus_req drops, go to DONE, O_err=1, cause 10, O_rdata=0 for reads.
  - A late ack arriving after a timeout is ignored.
- Bus outputs are held stable while in BUS.
- O_rdata is unchanged by writes and holds between loads.
- Latency, zero-wait slave (ack in first BUS cycle): request at cycle 0, O_bus_req cycles 1, O_done/O_rdata at cycle 2, O_stall high cycles 0-1.
- Back-to-back: a request accepted in DONE re-enters BUS next cycle, with no idle bubble.

Decomposition:
- Shared package riscv_pkg: opcode/funct3 constants already used by the core; dmem FSM state enum (IDLE, BUS, DONE); error cause constants ERR_NONE/ERR_BUS/ERR_TIMEOUT/ERR_MISALIGN.
- One natural sub-module: riscv_dmem_align, purely combinational: addr[1:0], wmask, wdata in; be, shifted wdata and misalign flag out.

Test Plan:
- SB, addr 0x1003, wdata 0x000000AB, wmask 0001, zero-wait ack -> O_bus_addr 0x1000, be 1000, wdata 0xAB000000, O_stall high 2 cycles, O_done at cycle 2, O_err 0.
- LW, addr 0x2000, ack after 3 wait cycles with rdata 0xDEADBEEF -> O_bus_req high 4 cycles, O_rdata 0xDEADBEEF in DONE and held afterwards, O_stall high 5 cycles.
- SW, addr 0x2002 -> no O_bus_req, O_done+O_err next cycle, cause 11, O_stall never asserted.
- LW with no ack, TIMEOUT=4 -> O_bus_req high 4 cycles then drops, O_err cause 10, O_rdata 0; a later stray ack has no effect.
- LW acked with I_bus_err=1 -> O_rdata 0, O_err cause 01; next LW without error -> O_rdata updated, O_err 0, O_err_cause still 01.
- I_rst asserted mid-BUS, asynchronously -> O_bus_req and O_stall 0 before the next clock edge; after release, IDLE, and a new LW completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: core opcode/funct3 constants plus data-memory
// controller state and error-cause encodings.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        DONE = 2'b10
    } dmem_state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BUS      = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_MISALIGN = 2'b11;

endpackage

// File: rtl/riscv_dmem_align.sv
// Byte-lane alignment of store data/mask and misalignment detection for the
// data-memory controller. Purely combinational.
module riscv_dmem_align (
    input  logic        i_we,
    input  logic [1:0]  i_addr_lo,
    input  logic [3:0]  i_wmask,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign
);

    always_comb begin
        o_be       = 4'b1111;
        o_wdata    = i_wdata << {i_addr_lo, 3'b000};
        o_misalign = 1'b0;
        if (i_we) begin
            o_be = 4'(i_wmask << i_addr_lo);
            unique case (i_wmask)
                4'b0011: o_misalign = i_addr_lo[0];
                4'b1111: o_misalign = |i_addr_lo;
                default: o_misalign = 1'b0;
            endcase
        end else begin
            // Loads carry no size information here, so they are checked as words.
            o_misalign = |i_addr_lo;
        end
    end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory controller: turns the core's registered load/store request into a
// single-outstanding req/ack bus access, with stall, error and timeout handling.
module riscv_dmem_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_rd,
    input  logic        I_we,
    input  logic [31:0] I_addr,
    input  logic [31:0] I_wdata,
    input  logic [3:0]  I_wmask,
    output logic [31:0] O_rdata,
    output logic        O_stall,
    output logic        O_done,
    output logic        O_err,
    output logic [1:0]  O_err_cause,
    output logic        O_bus_req,
    output logic        O_bus_we,
    output logic [31:0] O_bus_addr,
    output logic [31:0] O_bus_wdata,
    output logic [3:0]  O_bus_be,
    input  logic        I_bus_ack,
    input  logic [31:0] I_bus_rdata,
    input  logic        I_bus_err
);

    dmem_state_t          r_state, w_state_next;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic                 r_err;
    logic [1:0]           r_err_cause;
    logic [31:0]          r_rdata;
    logic                 r_bus_we;
    logic [31:0]          r_bus_addr;
    logic [31:0]          r_bus_wdata;
    logic [3:0]           r_bus_be;

    logic                 w_accept;
    logic                 w_misalign;
    logic                 w_timeout;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;
    logic                 w_err_next;
    logic [1:0]           w_cause_next;
    logic                 w_rdata_ld;
    logic [31:0]          w_rdata_val;

    riscv_dmem_align u_align (
        .i_we       (I_we),
        .i_addr_lo  (I_addr[1:0]),
        .i_wmask    (I_wmask),
        .i_wdata    (I_wdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_misalign (w_misalign)
    );

    assign w_accept  = (r_state != BUS) && (I_rd || I_we);
    assign w_timeout = (r_cnt == TIMEOUT_W'(TIMEOUT - 1));

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_err_next   = 1'b0;
        w_cause_next = r_err_cause;
        w_rdata_ld   = 1'b0;
        w_rdata_val  = '0;
        unique case (r_state)
            BUS: begin
                // An ack in the final counted cycle still wins over the timeout.
                if (I_bus_ack) begin
                    w_state_next = DONE;
                    w_rdata_ld   = !r_bus_we;
                    w_rdata_val  = I_bus_err ? '0 : I_bus_rdata;
                    if (I_bus_err) begin
                        w_err_next   = 1'b1;
                        w_cause_next = ERR_BUS;
                    end
                end else if (w_timeout) begin
                    w_state_next = DONE;
                    w_rdata_ld   = !r_bus_we;
                    w_err_next   = 1'b1;
                    w_cause_next = ERR_TIMEOUT;
                end
            end
            default: begin
                if (w_accept && w_misalign) begin
                    w_state_next = DONE;
                    w_rdata_ld   = !I_we;
                    w_err_next   = 1'b1;
                    w_cause_next = ERR_MISALIGN;
                end else if (w_accept) begin
                    w_state_next = BUS;
                end else begin
                    w_state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_err_cause <= ERR_NONE;
            r_rdata     <= '0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= '0;
        end else begin
            r_err       <= w_err_next;
            r_err_cause <= w_cause_next;
            if (w_rdata_ld) r_rdata <= w_rdata_val;
            if (r_state == BUS && !I_bus_ack && !w_timeout) r_cnt <= r_cnt + 1'b1;
            else                                            r_cnt <= '0;
            if (w_accept) begin
                r_bus_we    <= I_we;
                r_bus_addr  <= {I_addr[31:2], 2'b00};
                r_bus_wdata <= w_wdata;
                r_bus_be    <= w_be;
            end
        end
    end

    assign O_rdata     = r_rdata;
    assign O_stall     = (r_state == BUS) || (w_accept && !w_misalign);
    assign O_done      = (r_state == DONE);
    assign O_err       = r_err;
    assign O_err_cause = r_err_cause;
    assign O_bus_req   = (r_state == BUS);
    assign O_bus_we    = r_bus_we;
    assign O_bus_addr  = r_bus_addr;
    assign O_bus_wdata = r_bus_wdata;
    assign O_bus_be    = r_bus_be;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Directed, table-driven bench for riscv_dmem_ctrl with a short bus timeout so
// the timeout and last-cycle-ack boundaries are reachable quickly.
module tb_riscv_dmem_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, we;
    logic [31:0] addr, wdata;
    logic [3:0]  wmask;
    logic [31:0] O_rdata;
    logic        O_stall, O_done, O_err;
    logic [1:0]  O_err_cause;
    logic        O_bus_req, O_bus_we;
    logic [31:0] O_bus_addr, O_bus_wdata;
    logic [3:0]  O_bus_be;
    logic        ack;
    logic [31:0] brdata;
    logic        berr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    riscv_dmem_ctrl #(.TIMEOUT(TO), .TIMEOUT_W(8)) dut (
        .I_clk       (clk),
        .I_rst       (rst),
        .I_rd        (rd),
        .I_we        (we),
        .I_addr      (addr),
        .I_wdata     (wdata),
        .I_wmask     (wmask),
        .O_rdata     (O_rdata),
        .O_stall     (O_stall),
        .O_done      (O_done),
        .O_err       (O_err),
        .O_err_cause (O_err_cause),
        .O_bus_req   (O_bus_req),
        .O_bus_we    (O_bus_we),
        .O_bus_addr  (O_bus_addr),
        .O_bus_wdata (O_bus_wdata),
        .O_bus_be    (O_bus_be),
        .I_bus_ack   (ack),
        .I_bus_rdata (brdata),
        .I_bus_err   (berr)
    );

    typedef struct {
        logic        rd;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          ack_wait;   // bus cycles before ack; large = never
        logic [31:0] brdata;
        logic        berr;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        int          e_req;      // expected O_bus_req cycles (0 = misaligned)
        logic        e_err;
        logic [1:0]  e_cause;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic run_txn(input int id, input vec_t v);
        int          req_n, stall_n, cyc, done_cyc;
        logic [31:0] cap_addr, cap_wdata;
        logic [3:0]  cap_be;
        logic        cap_we;
        cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
        rd = v.rd; we = v.we; addr = v.addr; wdata = v.wdata; wmask = v.wmask;
        @(negedge clk);
        chk($sformatf("v%0d req_c0", id), 32'(O_bus_req), 32'd0);
        stall_n = int'(O_stall);
        @(posedge clk); #1;
        rd = 1'b0; we = 1'b0;
        req_n = 0; cyc = 1; done_cyc = -1;
        while (done_cyc < 0 && cyc < 20) begin
            if (O_bus_req && req_n == v.ack_wait) begin
                ack = 1'b1; brdata = v.brdata; berr = v.berr;
            end
            @(negedge clk);
            if (O_bus_req) begin
                if (req_n == 0) begin
                    cap_addr = O_bus_addr; cap_wdata = O_bus_wdata;
                    cap_be = O_bus_be; cap_we = O_bus_we;
                end
                req_n++;
            end
            if (O_stall) stall_n++;
            if (O_done) begin
                done_cyc = cyc;
                chk($sformatf("v%0d err", id), 32'(O_err), 32'(v.e_err));
                chk($sformatf("v%0d cause", id), 32'(O_err_cause), 32'(v.e_cause));
                chk($sformatf("v%0d rdata", id), O_rdata, v.e_rdata);
            end
            @(posedge clk); #1;
            ack = 1'b0; berr = 1'b0; brdata = '0;
            cyc++;
        end
        chk($sformatf("v%0d done_cycle", id), 32'(done_cyc), 32'(v.e_req + 1));
        chk($sformatf("v%0d req_cycles", id), 32'(req_n), 32'(v.e_req));
        chk($sformatf("v%0d stall_cycles", id), 32'(stall_n),
            32'((v.e_req == 0) ? 0 : v.e_req + 1));
        if (v.e_req > 0) begin
            chk($sformatf("v%0d bus_addr", id), cap_addr, v.e_addr);
            chk($sformatf("v%0d bus_wdata", id), cap_wdata, v.e_wdata);
            chk($sformatf("v%0d bus_be", id), 32'(cap_be), 32'(v.e_be));
            chk($sformatf("v%0d bus_we", id), 32'(cap_we), 32'(v.we));
        end
        @(negedge clk);
        chk($sformatf("v%0d post_done", id), 32'(O_done), 32'd0);
        chk($sformatf("v%0d post_err", id), 32'(O_err), 32'd0);
        chk($sformatf("v%0d post_rdata", id), O_rdata, v.e_rdata);
        chk($sformatf("v%0d post_req", id), 32'(O_bus_req), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t post;
        //           rd    we    addr          wdata         mask     wait brdata        berr  e_addr        e_wdata       e_be     req err   cause  e_rdata
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_1003, 32'h0000_00AB, 4'b0001, 0,  32'h0,         1'b0, 32'h0000_1000, 32'hAB00_0000, 4'b1000, 1, 1'b0, 2'b00, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         4'b1111, 3,  32'hDEAD_BEEF, 1'b0, 32'h0000_2000, 32'h0,         4'b1111, 4, 1'b0, 2'b00, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_2002, 32'h1234_5678, 4'b1111, 0,  32'h0,         1'b0, 32'h0,         32'h0,         4'b0000, 0, 1'b1, 2'b11, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,         4'b1111, 99, 32'h0,         1'b0, 32'h0000_3000, 32'h0,         4'b1111, 4, 1'b1, 2'b10, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,         4'b1111, 0,  32'h1234_5678, 1'b1, 32'h0000_4000, 32'h0,         4'b1111, 1, 1'b1, 2'b01, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_4004, 32'h0,         4'b1111, 1,  32'hCAFE_F00D, 1'b0, 32'h0000_4004, 32'h0,         4'b1111, 2, 1'b0, 2'b01, 32'hCAFE_F00D};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_5002, 32'h0000_BEEF, 4'b0011, 2,  32'h0,         1'b0, 32'h0000_5000, 32'hBEEF_0000, 4'b1100, 3, 1'b0, 2'b01, 32'hCAFE_F00D};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_5001, 32'h0000_1234, 4'b0011, 0,  32'h0,         1'b0, 32'h0,         32'h0,         4'b0000, 0, 1'b1, 2'b11, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_6001, 32'h0,         4'b0001, 0,  32'h0,         1'b0, 32'h0,         32'h0,         4'b0000, 0, 1'b1, 2'b11, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_7000, 32'h1122_3344, 4'b1111, 0,  32'h5555_5555, 1'b0, 32'h0000_7000, 32'h1122_3344, 4'b1111, 1, 1'b0, 2'b11, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_8001, 32'h0000_005A, 4'b0001, 1,  32'h0,         1'b0, 32'h0000_8000, 32'h0000_5A00, 4'b0010, 2, 1'b0, 2'b11, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_9004, 32'hDEAD_C0DE, 4'b1111, 0,  32'hFFFF_FFFF, 1'b1, 32'h0000_9004, 32'hDEAD_C0DE, 4'b1111, 1, 1'b1, 2'b01, 32'h0};
        post     = '{1'b1, 1'b0, 32'h0000_D000, 32'h0,         4'b1111, 1,  32'h1357_9BDF, 1'b0, 32'h0000_D000, 32'h0,         4'b1111, 2, 1'b0, 2'b00, 32'h1357_9BDF};

        rst = 1'b1; rd = 1'b0; we = 1'b0; addr = '0; wdata = '0; wmask = '0;
        ack = 1'b0; brdata = '0; berr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset bus_req", 32'(O_bus_req), 32'd0);
        chk("reset stall", 32'(O_stall), 32'd0);
        chk("reset done_err", {30'd0, O_done, O_err}, 32'd0);
        chk("reset rdata", O_rdata, 32'd0);
        chk("reset cause", 32'(O_err_cause), 32'd0);
        chk("reset bus_regs", O_bus_addr | O_bus_wdata | 32'(O_bus_be) | 32'(O_bus_we), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_txn(i, vecs[i]);
            if (vecs[i].ack_wait > 50) begin
                // Stray ack after a timeout must not complete anything.
                ack = 1'b1; brdata = 32'hFFFF_FFFF;
                @(negedge clk);
                chk("stray done", 32'(O_done), 32'd0);
                chk("stray stall", 32'(O_stall), 32'd0);
                @(posedge clk); #1;
                ack = 1'b0; brdata = '0;
                @(negedge clk);
                chk("stray rdata", O_rdata, 32'd0);
                chk("stray done2", {30'd0, O_done, O_err}, 32'd0);
                chk("stray cause", 32'(O_err_cause), 32'(2'b10));
                @(posedge clk); #1;
            end
        end

        // Back-to-back: a load accepted in DONE goes straight back to BUS.
        rd = 1'b1; addr = 32'h0000_A000;
        @(posedge clk); #1;
        rd = 1'b0; ack = 1'b1; brdata = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("b2b req1", 32'(O_bus_req), 32'd1);
        @(posedge clk); #1;
        ack = 1'b0; brdata = '0;
        rd = 1'b1; addr = 32'h0000_B000;
        @(negedge clk);
        chk("b2b done1", 32'(O_done), 32'd1);
        chk("b2b rdata1", O_rdata, 32'hA5A5_A5A5);
        chk("b2b stall_in_done", 32'(O_stall), 32'd1);
        @(posedge clk); #1;
        rd = 1'b0; ack = 1'b1; brdata = 32'h0F0F_0F0F;
        @(negedge clk);
        chk("b2b req2_no_bubble", 32'(O_bus_req), 32'd1);
        chk("b2b addr2", O_bus_addr, 32'h0000_B000);
        @(posedge clk); #1;
        ack = 1'b0; brdata = '0;
        @(negedge clk);
        chk("b2b done2", 32'(O_done), 32'd1);
        chk("b2b rdata2", O_rdata, 32'h0F0F_0F0F);
        chk("b2b cause_held", 32'(O_err_cause), 32'(2'b01));
        @(posedge clk); #1;

        // Asynchronous reset while the bus request is outstanding.
        rd = 1'b1; addr = 32'h0000_C000;
        @(posedge clk); #1;
        rd = 1'b0;
        @(negedge clk);
        chk("arst req_before", 32'(O_bus_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst req", 32'(O_bus_req), 32'd0);
        chk("arst stall", 32'(O_stall), 32'd0);
        chk("arst rdata", O_rdata, 32'd0);
        chk("arst cause", 32'(O_err_cause), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("arst idle_req", 32'(O_bus_req), 32'd0);
        chk("arst idle_done", 32'(O_done), 32'd0);
        @(posedge clk); #1;
        run_txn(100, post);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
